// File: rtl/mc_pkg.sv
// Shared memory-controller constants: read latency, reset level and slot-index width helper.
package mc_pkg;

  localparam int   READ_LATENCY = 1;
  localparam logic RST_ACTIVE   = 1'b0;

  // Width of a slot index for n arbitration slots; never narrower than one bit.
  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mc_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr, wrapping.
// Zero latency; next pointer is the slot after the winner, or ptr unchanged when nothing requests.
module mc_rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr_nxt
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/mc_rr_port_scheduler.sv
// Round-robin share of one single-port BRAM between load and store ports; grant is the handshake.
// Load data returns one cycle after grant and is held until accepted; a port waiting on its consumer is not regranted.
module mc_rr_port_scheduler
  import mc_pkg::*;
#(
  parameter int NUM_LOADS  = 2,
  parameter int NUM_STORES = 1,
  parameter int ADDR_TYPE  = 32,
  parameter int DATA_TYPE  = 32,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LOADS-1:0]            ld_addr_valid,
  output logic [NUM_LOADS-1:0]            ld_addr_ready,
  input  logic [NUM_LOADS*ADDR_TYPE-1:0]  ld_addr,
  output logic [NUM_LOADS-1:0]            ld_data_valid,
  input  logic [NUM_LOADS-1:0]            ld_data_ready,
  output logic [NUM_LOADS*DATA_TYPE-1:0]  ld_data,
  input  logic [NUM_STORES-1:0]           st_valid,
  output logic [NUM_STORES-1:0]           st_ready,
  input  logic [NUM_STORES*ADDR_TYPE-1:0] st_addr,
  input  logic [NUM_STORES*DATA_TYPE-1:0] st_data,
  input  logic                            cnt_valid,
  output logic                            cnt_ready,
  input  logic [CNT_W-1:0]                cnt,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_TYPE-1:0]            mem_addr,
  output logic [DATA_TYPE-1:0]            mem_din,
  input  logic [DATA_TYPE-1:0]            mem_dout,
  output logic                            all_done
);

  localparam int TOT = NUM_LOADS + NUM_STORES;
  localparam int PW  = slot_w(TOT);

  logic                    run;
  logic [TOT-1:0]          req;
  logic [TOT-1:0]          arb_gnt;
  logic [TOT-1:0]          gnt;
  logic [PW-1:0]           arb_ptr_nxt;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NUM_LOADS-1:0]    inflight_q, inflight_d;
  logic [NUM_LOADS-1:0]    dv_q, dv_d;
  logic [DATA_TYPE-1:0]    hold_q [NUM_LOADS];
  logic [DATA_TYPE-1:0]    hold_d [NUM_LOADS];
  logic signed [CNT_W-1:0] pend_q, pend_d;
  logic signed [CNT_W+1:0] pend_wide;
  logic                    pend_ovf;
  logic                    cnt_hs;
  logic                    st_any;

  assign run = (rst != RST_ACTIVE);

  // A load is eligible only if its data slot will be free next cycle.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_LOADS; i++)
      req[i] = ld_addr_valid[i] && (!ld_data_valid[i] || ld_data_ready[i]);
    for (int j = 0; j < NUM_STORES; j++)
      req[NUM_LOADS+j] = st_valid[j];
  end

  mc_rr_arbiter #(.N(TOT), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .ptr_nxt (arb_ptr_nxt)
  );

  assign gnt           = run ? arb_gnt : '0;
  assign ld_addr_ready = gnt[NUM_LOADS-1:0];
  assign st_ready      = gnt[TOT-1:NUM_LOADS];
  assign st_any        = |st_ready;
  assign mem_en        = |gnt;
  assign mem_we        = st_any;
  assign ptr_d         = (|gnt) ? arb_ptr_nxt : ptr_q;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    for (int i = 0; i < NUM_LOADS; i++)
      if (gnt[i]) mem_addr = ld_addr[i*ADDR_TYPE +: ADDR_TYPE];
    for (int j = 0; j < NUM_STORES; j++)
      if (gnt[NUM_LOADS+j]) begin
        mem_addr = st_addr[j*ADDR_TYPE +: ADDR_TYPE];
        mem_din  = st_data[j*DATA_TYPE +: DATA_TYPE];
      end
  end

  // Returning read is bypassed straight from mem_dout, then served from the hold reg.
  always_comb begin
    inflight_d    = gnt[NUM_LOADS-1:0];
    ld_data_valid = '0;
    ld_data       = '0;
    dv_d          = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      hold_d[i]                          = inflight_q[i] ? mem_dout : hold_q[i];
      ld_data_valid[i]                   = inflight_q[i] | dv_q[i];
      ld_data[i*DATA_TYPE +: DATA_TYPE]  = inflight_q[i] ? mem_dout : hold_q[i];
      dv_d[i]                            = ld_data_valid[i] & ~ld_data_ready[i];
    end
  end

  assign cnt_ready = run;
  assign cnt_hs    = cnt_valid & cnt_ready;

  // Two guard bits catch signed overflow of the pending-store count.
  always_comb begin
    pend_wide = {{2{pend_q[CNT_W-1]}}, pend_q}
              + (cnt_hs ? {2'b00, cnt} : '0)
              - (CNT_W+2)'(st_any);
    pend_d    = pend_wide[CNT_W-1:0];
    pend_ovf  = (pend_wide[CNT_W+1:CNT_W-1] != 3'b000) &&
                (pend_wide[CNT_W+1:CNT_W-1] != 3'b111);
  end

  assign all_done = run && (pend_q == '0) && (inflight_q == '0) && !cnt_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      dv_q       <= '0;
      pend_q     <= '0;
      for (int i = 0; i < NUM_LOADS; i++) hold_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      dv_q       <= dv_d;
      pend_q     <= pend_d;
      for (int i = 0; i < NUM_LOADS; i++) hold_q[i] <= hold_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (run) assert (!pend_ovf);
  end

endmodule

// File: tb/tb_mc_rr_port_scheduler.sv
// Directed bench for mc_rr_port_scheduler: reset, fairness, backpressure, store counting,
// back-to-back loads and mid-operation reset, checked with immediate assertions.
module tb_mc_rr_port_scheduler;

  localparam int NL = 2;
  localparam int NS = 1;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NL-1:0]    ld_addr_valid, ld_addr_ready, ld_data_valid, ld_data_ready;
  logic [NL*AW-1:0] ld_addr;
  logic [NL*DW-1:0] ld_data;
  logic [NS-1:0]    st_valid, st_ready;
  logic [NS*AW-1:0] st_addr;
  logic [NS*DW-1:0] st_data;
  logic             cnt_valid, cnt_ready;
  logic [CW-1:0]    cnt;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_din, mem_dout;
  logic             all_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_rr_port_scheduler #(
    .NUM_LOADS(NL), .NUM_STORES(NS), .ADDR_TYPE(AW), .DATA_TYPE(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_addr_valid(ld_addr_valid), .ld_addr_ready(ld_addr_ready), .ld_addr(ld_addr),
    .ld_data_valid(ld_data_valid), .ld_data_ready(ld_data_ready), .ld_data(ld_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt(cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .all_done(all_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  exp_g;
    logic [31:0] exp_a;

    // Reset held with every request asserted.
    ld_addr_valid = 2'b11; ld_data_ready = 2'b11;
    ld_addr = {32'h200, 32'h100};
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'hDEAD;
    cnt_valid = 1'b1; cnt = '0; mem_dout = '0;
    #1;
    chk("rst_mem_en",   64'(mem_en), 64'(0));
    chk("rst_ld_rdy",   64'(ld_addr_ready), 64'(0));
    chk("rst_st_rdy",   64'(st_ready), 64'(0));
    chk("rst_cnt_rdy",  64'(cnt_ready), 64'(0));
    chk("rst_all_done", 64'(all_done), 64'(0));
    chk("rst_ld_dv",    64'(ld_data_valid), 64'(0));
    tick; tick;
    chk("rst_hold_en",  64'(mem_en), 64'(0));

    // Release: first grant in the same cycle goes to slot 0, then strict rotation.
    cnt_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      exp_a = (k % 3 == 0) ? 32'h100 : (k % 3 == 1) ? 32'h200 : 32'h300;
      chk("fair_gnt",  64'({st_ready, ld_addr_ready}), 64'(exp_g));
      chk("fair_we",   64'(mem_we), 64'(k % 3 == 2));
      chk("fair_addr", 64'(mem_addr), 64'(exp_a));
      if (k % 3 == 2) chk("fair_din", 64'(mem_din), 64'(32'hDEAD));
      tick;
    end

    // Idle: muxed fields are zero; two stores left pending at -2.
    ld_addr_valid = 2'b00; st_valid = 1'b0;
    #1;
    chk("idle_en",   64'(mem_en), 64'(0));
    chk("idle_addr", 64'(mem_addr), 64'(0));
    chk("idle_din",  64'(mem_din), 64'(0));
    chk("idle_done_neg", 64'(all_done), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst2_dv", 64'(ld_data_valid), 64'(0));
    tick;
    rst = 1'b1;
    #1;

    // Backpressure on load port 0.
    ld_addr[31:0] = 32'h10; ld_addr_valid = 2'b01; ld_data_ready = 2'b00;
    #1;
    chk("bp_gnt",  64'(ld_addr_ready), 64'(2'b01));
    chk("bp_addr", 64'(mem_addr), 64'(32'h10));
    tick;
    mem_dout = 32'hAB;
    #1;
    chk("bp_v0",  64'(ld_data_valid), 64'(2'b01));
    chk("bp_d0",  64'(ld_data[31:0]), 64'(32'hAB));
    chk("bp_ng0", 64'(ld_addr_ready), 64'(0));
    tick;
    for (int i = 0; i < 2; i++) begin
      mem_dout = 32'h55 + 32'(i);
      #1;
      chk("bp_v_hold",  64'(ld_data_valid), 64'(2'b01));
      chk("bp_d_hold",  64'(ld_data[31:0]), 64'(32'hAB));
      chk("bp_ng_hold", 64'(ld_addr_ready), 64'(0));
      tick;
    end
    ld_data_ready = 2'b01;
    #1;
    chk("bp_v_rel",  64'(ld_data_valid), 64'(2'b01));
    chk("bp_d_rel",  64'(ld_data[31:0]), 64'(32'hAB));
    chk("bp_regrant", 64'(ld_addr_ready), 64'(2'b01));
    tick;
    ld_addr_valid = 2'b00; mem_dout = 32'hCD;
    #1;
    chk("bp_v_new", 64'(ld_data_valid), 64'(2'b01));
    chk("bp_d_new", 64'(ld_data[31:0]), 64'(32'hCD));
    tick;
    chk("bp_v_clr",  64'(ld_data_valid), 64'(0));
    chk("bp_done",   64'(all_done), 64'(1));

    // Stores ahead of their token, then token and store together.
    st_valid = 1'b1;
    #1;
    chk("cnt_st_rdy", 64'(st_ready), 64'(1));
    chk("cnt_st_we",  64'(mem_we), 64'(1));
    tick;
    chk("cnt_st_rdy2", 64'(st_ready), 64'(1));
    tick;
    st_valid = 1'b0;
    #1;
    chk("cnt_neg_done", 64'(all_done), 64'(0));
    cnt_valid = 1'b1; cnt = 16'd2;
    #1;
    chk("cnt_rdy",      64'(cnt_ready), 64'(1));
    chk("cnt_tok_done", 64'(all_done), 64'(0));
    tick;
    cnt_valid = 1'b0;
    #1;
    chk("cnt_bal_done", 64'(all_done), 64'(1));
    cnt_valid = 1'b1; cnt = 16'd3; st_valid = 1'b1;
    tick;
    cnt_valid = 1'b0; st_valid = 1'b0;
    #1;
    chk("cnt_p2_done", 64'(all_done), 64'(0));
    st_valid = 1'b1;
    tick;
    st_valid = 1'b0;
    #1;
    chk("cnt_p1_done", 64'(all_done), 64'(0));
    st_valid = 1'b1;
    tick;
    st_valid = 1'b0;
    #1;
    chk("cnt_p0_done", 64'(all_done), 64'(1));

    // Back-to-back loads on port 1.
    ld_data_ready = 2'b11;
    for (int k = 0; k < 5; k++) begin
      ld_addr_valid = (k < 4) ? 2'b10 : 2'b00;
      ld_addr[63:32] = 32'(k);
      mem_dout = 32'hF0 + 32'(k);
      #1;
      if (k < 4) begin
        chk("b2b_gnt",  64'(ld_addr_ready), 64'(2'b10));
        chk("b2b_addr", 64'(mem_addr), 64'(k));
      end
      if (k >= 1) begin
        chk("b2b_v", 64'(ld_data_valid[1]), 64'(1));
        chk("b2b_d", 64'(ld_data[63:32]), 64'(32'hF0 + 32'(k)));
      end
      tick;
    end
    chk("b2b_v_clr", 64'(ld_data_valid), 64'(0));

    // Reset the cycle after a load grant drops the read.
    ld_addr_valid = 2'b01;
    #1;
    chk("mid_gnt", 64'(ld_addr_ready), 64'(2'b01));
    tick;
    ld_addr_valid = 2'b00; rst = 1'b0;
    #1;
    chk("mid_dv_rst", 64'(ld_data_valid), 64'(0));
    tick;
    rst = 1'b1;
    #1;
    chk("mid_dv_rel",  64'(ld_data_valid), 64'(0));
    chk("mid_done",    64'(all_done), 64'(1));
    tick;
    chk("mid_dv_late", 64'(ld_data_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
